cic_comb_decim: RTL and testbench
=================================

# cic_comb_decim

Decimating comb stage for the 8-bit integrator datapath. It consumes the modulo-2^LEN accumulator stream the integrator stage produces every clock. It keeps one sample in every DECIM and outputs the modular difference y_k = s_k − s_{k−M}, which cancels the integrator's wrap-around. The result is presented on a valid/ready output with a sticky overflow flag, because the integrator upstream cannot be stalled.

## Interface
Parameters:
- LEN, 8, data width of input and output samples
- DECIM, 4, decimation factor (≥1); 1 means every input is kept
- M, 1, differential delay in decimated samples (1 or 2)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- din  input  LEN  integrator output, new sample every cycle, no valid qualifier
- dout  output  LEN  comb result y_k
- dout_valid  output  1  dout holds an unconsumed result
- dout_ready  input  1  downstream accepts dout at this edge when dout_valid=1
- overflow  output  1  sticky: a result was overwritten before acceptance

## Operation
- Reset values:
  - dout=0, dout_valid=0, overflow=0.
  - Phase counter cnt=0.
  - History registers = 0.
  - State = PRIME, prime count = 0.
- Phase counter cnt counts 0..DECIM−1 and wraps to 0. It advances every non-reset cycle.
- A capture occurs at an edge with cnt==0. The sample taken is din at that edge and is s_k.
  - Input sample n=0 is the first edge with rst low.
  - Captures therefore occur at n=0, DECIM, 2·DECIM, …
- History is an M-deep shift register of captured samples. It shifts only on capture.
- State machine:
  - PRIME:
    - On capture, push s_k into history and increment the prime count. No result is produced.
    - After M captures, go to RUN.
  - RUN:
    - On capture, compute y_k = (s_k − s_{k−M}) mod 2^LEN.
    - Push s_k into history and load y_k into the output register.
  - RUN is left only by rst.
- Arithmetic: compute at LEN+1 bits, keep the low LEN bits, and discard the borrow. No saturation.
- Output handshake:
  - A transfer happens at an edge with dout_valid=1 and dout_ready=1.
  - With no new result at that edge, dout_valid clears on the next cycle and dout holds its last value.
  - New result, and dout_valid=0 or a transfer at the same edge: load dout, set dout_valid=1, overflow unchanged.
  - New result, dout_valid=1, dout_ready=0: overwrite dout, dout_valid stays 1, and overflow is set.
  - overflow clears only on rst.
  - dout and dout_valid never change while dout_valid=1 and dout_ready=0, except on overwrite.
- dout_ready is ignored while dout_valid=0.
- Reset mid-operation: at the next edge all state returns to reset values. Priming restarts and any pending result is dropped.

## Timing
- Latency: y_k appears on dout with dout_valid=1 in the cycle immediately after the capture edge of s_k.
- Output rate: at most one result per DECIM cycles.
- First result: captured at n=M·DECIM, visible in the following cycle.
- DECIM=1: capture every edge. With dout_ready held high, dout_valid stays continuously 1 once in RUN.
- No combinational path from din or dout_ready to any output. All outputs are registered.

## Test plan
- Reset:
  - Stimulus: rst=1 for 3 cycles with din=0x55 and dout_ready=0.
  - Required: dout=0x00, dout_valid=0 and overflow=0 throughout and in the first cycle after release.
  - Required: no dout_valid before the edge at n=M·DECIM.
- Ramp with wrap (LEN=8, DECIM=4, M=1, dout_ready=1):
  - Stimulus: din=(2n) mod 256 from n=0.
  - Required: first dout_valid pulse in the cycle after n=4, dout=0x08.
  - Required: a one-cycle pulse with dout=0x08 every 4 cycles, including across the wrap s=0xF8→0x00.
- Backpressure/overflow (same config):
  - Stimulus: dout_ready=0 after the first result.
  - Required: dout_valid stays 1 and dout holds 0x08.
  - Required: at the next capture, dout is overwritten, overflow=1 and stays 1 after dout_ready returns.
  - Required: overflow clears only on rst.
- Simultaneous accept and new result:
  - Stimulus: dout_ready pulsed high only on the capture edge while dout_valid=1.
  - Required: the new result loads, dout_valid stays 1 and overflow stays 0.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle at cnt=2 while in RUN.
  - Required: next cycle dout=0, dout_valid=0.
  - Required: cnt restarts at 0, and the next dout_valid is in the cycle after n=4 relative to release.
- M=2, DECIM=1:
  - Stimulus: din=n mod 256 with dout_ready=1.
  - Required: dout_valid first high in the cycle after n=2, then continuously high with dout=0x02.
  - Required: at n=0x00 after 0xFE,0xFF, dout=0x02.

Source files
------------

// File: rtl/cic_comb_decim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cic_comb_decim
//  Description : Decimating comb stage for a CIC integrator datapath.
//                Keeps one input sample in every DECIM (s_k) and outputs the
//                modular difference y_k = s_k - s_{k-M}. That difference
//                cancels the modulo-2^LEN wrap-around of the upstream
//                integrator. Results are held on a valid/ready output
//                register. The integrator upstream cannot be stalled, so an
//                unaccepted result is overwritten by the next one and a
//                sticky overflow flag is raised.
//
//  Ports       : clk        - clock, all logic on the rising edge
//                rst        - synchronous active-high reset
//                din        - integrator sample, new value every cycle
//                dout       - comb result y_k (registered)
//                dout_valid - dout holds an unconsumed result
//                dout_ready - downstream accepts dout when dout_valid=1
//                overflow   - sticky; a result was overwritten unconsumed
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_comb_decim #(
    parameter int LEN   = 8,   // sample width
    parameter int DECIM = 4,   // decimation factor, >= 1
    parameter int M     = 1    // differential delay in decimated samples, 1 or 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] din,
    output logic [LEN-1:0] dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic           overflow
);

    localparam int                 c_CNT_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(DECIM - 1);
    localparam logic [1:0]         c_PRIME_NUM = 2'(M);

    typedef enum logic [0:0] {
        PRIME = 1'b0,   // filling the history, no results yet
        RUN   = 1'b1    // history full, every capture yields a result
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_prime_cnt;
    logic [1:0]         w_prime_cnt_nxt;
    logic [M*LEN-1:0]   r_hist;        // newest capture in the low LEN bits
    logic [LEN-1:0]     w_oldest;      // s_{k-M}
    logic [LEN-1:0]     w_diff;
    logic               w_capture;
    logic               w_new_result;

    // ------------------------------------------------------------------------
    // Phase counter: a capture happens whenever the counter is at zero, so the
    // first cycle out of reset is always a capture.
    // ------------------------------------------------------------------------
    assign w_capture = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // History shift register of captured samples, advancing on capture only.
    // ------------------------------------------------------------------------
    generate
        if (M == 1) begin : g_hist_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hist <= '0;
                end else if (w_capture) begin
                    r_hist <= din;
                end
            end
        end else begin : g_hist_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hist <= '0;
                end else if (w_capture) begin
                    r_hist <= {r_hist[(M-1)*LEN-1:0], din};
                end
            end
        end
    endgenerate

    assign w_oldest = r_hist[M*LEN-1 -: LEN];

    // Subtracting in LEN bits is the LEN+1-bit difference with its borrow
    // discarded: exactly the modular result that undoes integrator wrap.
    assign w_diff = din - w_oldest;

    // ------------------------------------------------------------------------
    // Priming state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PRIME;
            r_prime_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_prime_cnt <= w_prime_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_prime_cnt_nxt = r_prime_cnt;
        w_new_result    = 1'b0;
        case (r_state)
            PRIME: begin
                if (w_capture) begin
                    w_prime_cnt_nxt = r_prime_cnt + 2'd1;
                    if (w_prime_cnt_nxt == c_PRIME_NUM) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_new_result = w_capture;
            end
            default: begin
                w_state_nxt = PRIME;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output register. A new result always wins: it is loaded even when the
    // previous one is still pending, and that loss is recorded in overflow.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (w_new_result) begin
            dout       <= w_diff;
            dout_valid <= 1'b1;
            if (dout_valid && !dout_ready) begin
                overflow <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_comb_decim.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cic_comb_decim
//  Description : Self-checking bench for cic_comb_decim. One instance uses
//                LEN=8/DECIM=4/M=1 and is driven from a vector table, with
//                a result scoreboard alongside. A second instance uses
//                LEN=8/DECIM=1/M=2 and runs a hand-written ramp sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_comb_decim;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DECIM=4, M=1
    logic       rst;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overflow;

    // Instance B: DECIM=1, M=2
    logic       rst2;
    logic [7:0] din2;
    logic [7:0] dout2;
    logic       dout_valid2;
    logic       dout_ready2;
    logic       overflow2;

    cic_comb_decim #(.LEN(8), .DECIM(4), .M(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

    cic_comb_decim #(.LEN(8), .DECIM(1), .M(2)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .din        (din2),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .dout_ready (dout_ready2),
        .overflow   (overflow2)
    );

    typedef struct {
        logic       rst;
        logic [7:0] din;
        logic       rdy;
        logic       ev;   // expected dout_valid after the edge
        logic [7:0] ed;   // expected dout after the edge
        logic       eo;   // expected overflow after the edge
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic void add(input logic r, input logic [7:0] d, input logic rd,
                                input logic ev, input logic [7:0] ed, input logic eo);
        vec_t v;
        v.rst = r; v.din = d; v.rdy = rd; v.ev = ev; v.ed = ed; v.eo = eo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        int         ph;
        int         caps;
        logic [7:0] last_s;
        logic       pushed;

        rst = 1'b1; din = 8'h55; dout_ready = 1'b0;
        rst2 = 1'b1; din2 = 8'h00; dout_ready2 = 1'b1;
        ph = 0; caps = 0; last_s = 8'h00;

        // ---------------- vector table, instance A ----------------
        // reset held 3 cycles with din=0x55, dout_ready=0
        for (int k = 0; k < 3; k++) add(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        // ramp din=2n across the 0xF8 -> 0x00 wrap, dout_ready=1
        for (int n = 0; n < 140; n++)
            add(1'b0, 8'(2*n), 1'b1, (n >= 4 && n % 4 == 0), (n >= 4) ? 8'h08 : 8'h00, 1'b0);
        // accept coinciding with a new result (capture at 144)
        add(1'b0, 8'(2*140), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*141), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*142), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*143), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*144), 1'b1, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*145), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*146), 1'b1, 1'b0, 8'h08, 1'b0);
        add(1'b0, 8'(2*147), 1'b1, 1'b0, 8'h08, 1'b0);
        // backpressure: overwrite at 152, sticky overflow afterwards
        add(1'b0, 8'(2*148), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*149), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*150), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*151), 1'b0, 1'b1, 8'h08, 1'b0);
        add(1'b0, 8'(2*152), 1'b0, 1'b1, 8'h08, 1'b1);
        add(1'b0, 8'(2*153), 1'b1, 1'b0, 8'h08, 1'b1);
        add(1'b0, 8'(2*154), 1'b1, 1'b0, 8'h08, 1'b1);
        add(1'b0, 8'(2*155), 1'b1, 1'b0, 8'h08, 1'b1);
        add(1'b0, 8'(2*156), 1'b1, 1'b1, 8'h08, 1'b1);
        add(1'b0, 8'(2*157), 1'b1, 1'b0, 8'h08, 1'b1);
        // one-cycle reset at cnt=2 while in RUN, then re-prime
        add(1'b1, 8'(2*158), 1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++)
            add(1'b0, 8'(2*(159+k)), 1'b1, (k == 4 || k == 8), (k >= 4) ? 8'h08 : 8'h00, 1'b0);

        // ---------------- apply table ----------------
        foreach (vecs[i]) begin
            pushed     = 1'b0;
            rst        = vecs[i].rst;
            din        = vecs[i].din;
            dout_ready = vecs[i].rdy;
            if (vecs[i].rst) begin
                ph = 0; caps = 0; last_s = 8'h00;
                sb_q.delete();
            end else begin
                if (ph == 0) begin
                    if (caps >= 1) begin
                        sb_q.push_back(8'(vecs[i].din - last_s));
                        pushed = 1'b1;
                    end
                    last_s = vecs[i].din;
                    caps++;
                end
                ph = (ph + 1) % 4;
            end
            @(posedge clk); #1;
            check("dout_valid", i, 32'(dout_valid), 32'(vecs[i].ev));
            check("dout",       i, 32'(dout),       32'(vecs[i].ed));
            check("overflow",   i, 32'(overflow),   32'(vecs[i].eo));
            if (pushed) begin
                if (dout_valid && sb_q.size() > 0) begin
                    check("sb_result", i, 32'(dout), 32'(sb_q.pop_front()));
                end else begin
                    check("sb_result_valid", i, 32'(dout_valid), 32'd1);
                end
            end
        end
        check("sb_leftover", 0, 32'(sb_q.size()), 32'd0);

        // ---------------- instance B: M=2, DECIM=1 ----------------
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rst2 = 1'b1; din2 = 8'h00;
            @(posedge clk); #1;
            check("b_reset_valid", k, 32'(dout_valid2), 32'd0);
            check("b_reset_dout",  k, 32'(dout2),       32'd0);
        end
        rst2 = 1'b0;
        for (int n = 0; n < 300; n++) begin
            din2 = 8'(n);
            @(posedge clk); #1;
            if (n == 256) begin
                check("b_wrap_dout",  n, 32'(dout2),       32'h02);
                check("b_wrap_valid", n, 32'(dout_valid2), 32'd1);
            end else begin
                check("b_valid", n, 32'(dout_valid2), (n >= 2) ? 32'd1 : 32'd0);
                check("b_dout",  n, 32'(dout2),       (n >= 2) ? 32'h02 : 32'h00);
            end
            check("b_overflow", n, 32'(overflow2), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
